// File: rtl/calc_display_scan_if.sv
// Operand capture and display scan signals between the calculator core and the display driver.
interface calc_display_scan_if;
  logic        load;
  logic [13:0] value_in;
  logic        neg_in;
  logic        busy;
  logic [1:0]  select;
  logic [3:0]  anode;
  logic [6:0]  seg_out;
  logic        neg_flag;

  modport master (
    output load, value_in, neg_in,
    input  busy, select, anode, seg_out, neg_flag
  );

  modport slave (
    input  load, value_in, neg_in,
    output busy, select, anode, seg_out, neg_flag
  );
endinterface

// File: rtl/calc_display_scan.sv
// Four-digit seven-segment driver: iterative binary-to-BCD conversion, atomic commit,
// leading-zero blanking, overflow dashes and time-multiplexed digit scan.
module calc_display_scan #(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter bit          BLANK_LZ    = 1'b1
) (
  input logic           clk,
  input logic           rst_n,
  calc_display_scan_if.slave bus
);
  localparam int unsigned VW = 14;
  localparam int unsigned BW = 16;
  localparam int unsigned RW = $clog2(REFRESH_DIV);
  localparam logic [6:0]  SEG_BLANK = 7'b1111111;
  localparam logic [6:0]  SEG_DASH  = 7'b0111111;

  logic            r_busy;
  logic [3:0]      r_cnt;
  logic [VW-1:0]   r_bin;
  logic [BW-1:0]   r_bcd;
  logic            r_neg;
  logic            r_ovf;
  logic [3:0][6:0] r_disp;
  logic            r_neg_flag;
  logic [RW-1:0]   r_refresh;
  logic [1:0]      r_select;
  logic [3:0]      r_anode;
  logic [6:0]      r_seg;

  logic [BW-1:0]   w_bcd_adj;
  logic [3:0][6:0] w_disp_new;
  logic            w_commit;
  logic            w_ovf_in;
  logic            w_wrap;
  logic [1:0]      w_select_next;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = SEG_BLANK;
    endcase
  endfunction

  assign w_commit = r_busy && (r_cnt == 4'd0);
  // Digit 3 is reserved for the sign, so negative results are limited to three digits.
  assign w_ovf_in = (bus.value_in > VW'(9999)) || (bus.neg_in && (bus.value_in > VW'(999)));

  // Shift-add-3 correction applied before each shift
  always_comb begin
    w_bcd_adj = r_bcd;
    for (int i = 0; i < 4; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
    end
  end

  // Segment patterns committed at the end of a conversion
  always_comb begin
    for (int i = 0; i < 4; i++) w_disp_new[i] = seg7(r_bcd[4*i +: 4]);
    if (BLANK_LZ && (r_bcd[15:12] == 4'd0)) begin
      w_disp_new[3] = SEG_BLANK;
      if (r_bcd[11:8] == 4'd0) begin
        w_disp_new[2] = SEG_BLANK;
        if (r_bcd[7:4] == 4'd0) w_disp_new[1] = SEG_BLANK;
      end
    end
    if (r_neg) w_disp_new[3] = SEG_BLANK;
    if (r_ovf) w_disp_new = {4{SEG_DASH}};
  end

  // Conversion engine; a new load always wins over the running conversion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
      r_cnt  <= 4'd0;
      r_bin  <= '0;
      r_bcd  <= '0;
      r_neg  <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (bus.load) begin
      r_busy <= 1'b1;
      r_cnt  <= 4'd14;
      r_bin  <= bus.value_in;
      r_bcd  <= '0;
      r_neg  <= bus.neg_in;
      r_ovf  <= w_ovf_in;
    end else if (w_commit) begin
      r_busy <= 1'b0;
    end else if (r_busy) begin
      r_bcd <= {w_bcd_adj[BW-2:0], r_bin[VW-1]};
      r_bin <= {r_bin[VW-2:0], 1'b0};
      r_cnt <= r_cnt - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_disp     <= {4{SEG_BLANK}};
      r_neg_flag <= 1'b0;
    end else if (w_commit) begin
      r_disp     <= w_disp_new;
      r_neg_flag <= r_neg && !r_ovf;
    end
  end

  assign w_wrap        = (r_refresh == RW'(REFRESH_DIV - 1));
  assign w_select_next = w_wrap ? r_select + 2'd1 : r_select;

  // Anode and segments load from the same next-select value so they never disagree
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_refresh <= '0;
      r_select  <= 2'd0;
      r_anode   <= 4'b1110;
      r_seg     <= SEG_BLANK;
    end else begin
      r_refresh <= w_wrap ? '0 : r_refresh + RW'(1);
      r_select  <= w_select_next;
      r_anode   <= ~(4'b0001 << w_select_next);
      r_seg     <= r_disp[w_select_next];
    end
  end

  assign bus.busy     = r_busy;
  assign bus.select   = r_select;
  assign bus.anode    = r_anode;
  assign bus.seg_out  = r_seg;
  assign bus.neg_flag = r_neg_flag;
endmodule

// File: tb/tb_calc_display_scan.sv
// Bench for calc_display_scan: directed cases plus random loads against a decimal reference model.
module tb_calc_display_scan;
  localparam int unsigned DIV = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  logic [6:0] exp_seg [4];
  logic       exp_neg;
  logic [6:0] seg_tab [10];

  calc_display_scan_if bus();

  calc_display_scan #(.REFRESH_DIV(DIV), .BLANK_LZ(1'b1)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Edges since reset release; the scan position follows from this alone
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_scan(input string tag);
    int s;
    logic [3:0] a;
    s = (cyc / int'(DIV)) % 4;
    a = ~(4'b0001 << s);
    check_eq({tag, "/select"}, 32'(bus.select), 32'(s));
    check_eq({tag, "/anode"},  32'(bus.anode),  32'(a));
    check_eq({tag, "/seg"},    32'(bus.seg_out), 32'(exp_seg[s]));
  endtask

  task automatic model_commit(input int v, input bit n);
    bit ovf;
    int d [4];
    int top;
    int p;
    ovf = (v > 9999) || (n && v > 999);
    top = 0;
    p   = 1;
    for (int i = 0; i < 4; i++) begin
      d[i] = (v / p) % 10;
      if (d[i] != 0) top = i;
      p = p * 10;
    end
    for (int i = 0; i < 4; i++) begin
      if (ovf)                        exp_seg[i] = 7'b0111111;
      else if (i > top || (i == 3 && n)) exp_seg[i] = 7'b1111111;
      else                            exp_seg[i] = seg_tab[d[i]];
    end
    exp_neg = n && !ovf;
  endtask

  task automatic do_load(input int v, input bit n);
    bus.load     = 1'b1;
    bus.value_in = 14'(v);
    bus.neg_in   = n;
    tick();
    bus.load     = 1'b0;
  endtask

  // Called just after the load edge; checks the old display is held, then the new one
  task automatic wait_commit(input string tag, input int exp_len, input int v, input bit n);
    int k;
    k = 0;
    while (bus.busy === 1'b1 && k < 40) begin
      check_scan({tag, "/hold"});
      tick();
      k++;
    end
    check_eq({tag, "/busy_len"}, 32'(k), 32'(exp_len));
    check_scan({tag, "/hold"});
    model_commit(v, n);
    check_eq({tag, "/neg_flag"}, 32'(bus.neg_flag), 32'(exp_neg));
    tick();
    repeat (16) begin
      check_scan(tag);
      tick();
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "/busy"},     32'(bus.busy),     32'(0));
    check_eq({tag, "/select"},   32'(bus.select),   32'(0));
    check_eq({tag, "/anode"},    32'(bus.anode),    32'(4'b1110));
    check_eq({tag, "/seg"},      32'(bus.seg_out),  32'(7'b1111111));
    check_eq({tag, "/neg_flag"}, 32'(bus.neg_flag), 32'(0));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int v;
    bit n;
    seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    for (int i = 0; i < 4; i++) exp_seg[i] = 7'b1111111;
    exp_neg      = 1'b0;
    bus.load     = 1'b0;
    bus.value_in = '0;
    bus.neg_in   = 1'b0;

    #3 rst_n = 1'b0;
    #1 check_reset_vals("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;

    repeat (20) begin
      check_scan("scan_idle");
      tick();
    end

    do_load(1234, 1'b0);  wait_commit("pos1234", 15, 1234, 1'b0);
    do_load(7, 1'b1);     wait_commit("neg7", 15, 7, 1'b1);
    do_load(0, 1'b0);     wait_commit("zero", 15, 0, 1'b0);
    do_load(10000, 1'b0); wait_commit("ovf_pos", 15, 10000, 1'b0);
    do_load(1000, 1'b1);  wait_commit("ovf_neg", 15, 1000, 1'b1);
    do_load(999, 1'b1);   wait_commit("neg999", 15, 999, 1'b1);
    do_load(9999, 1'b0);  wait_commit("max9999", 15, 9999, 1'b0);

    // Restart: the discarded 5678 must never reach the display
    do_load(5678, 1'b0);
    repeat (3) begin
      check_scan("restart/hold");
      tick();
    end
    do_load(42, 1'b0);
    wait_commit("restart42", 15, 42, 1'b0);

    // Load on the commit edge of a prior conversion
    do_load(300, 1'b0);
    repeat (14) begin
      check_scan("b2b/hold");
      tick();
    end
    do_load(8765, 1'b0);
    check_scan("b2b/hold");
    model_commit(300, 1'b0);
    check_eq("b2b/busy", 32'(bus.busy), 32'(1));
    check_eq("b2b/neg_flag", 32'(bus.neg_flag), 32'(exp_neg));
    tick();
    wait_commit("b2b_second", 14, 8765, 1'b0);

    // Reset in the middle of a conversion
    do_load(321, 1'b1);
    repeat (6) tick();
    rst_n = 1'b0;
    #1 check_reset_vals("reset_mid");
    for (int i = 0; i < 4; i++) exp_seg[i] = 7'b1111111;
    exp_neg = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (20) begin
      check_scan("after_reset");
      check_eq("after_reset/busy", 32'(bus.busy), 32'(0));
      check_eq("after_reset/neg_flag", 32'(bus.neg_flag), 32'(0));
      tick();
    end

    repeat (12) begin
      v = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 16383)) : int'($urandom_range(0, 1100));
      n = 1'($urandom_range(0, 1));
      do_load(v, n);
      wait_commit("random", 15, v, n);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
